decoder_scan_seq: RTL
=====================

# decoder_scan_seq

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two operating modes.
- Direct mode: decodes a loaded select value.
- Scan mode: an internal index steps through every output line, dwelling DIV cycles on each, with a wrap pulse at the end of each sweep.

It drives one-hot select lines (bank, digit or channel enables) from the datapath, replacing the fixed combinational 3-to-8 decode wherever registered, glitch-free or auto-scanned selects are needed.

## Interface
Parameters:
- SEL_W, default 3: select width. Output width OUT_W = 2**SEL_W is derived, not overridable.
- DIV, default 4: dwell cycles per index in scan mode. Must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  block enable. 0 forces IDLE.
- mode  in  1  0 = direct, 1 = scan. Sampled when en=1.
- load  in  1  direct mode: capture sel_in this edge. Ignored in scan mode.
- sel_in  in  SEL_W  index to decode in direct mode.
- y  out  OUT_W  registered one-hot select. All zero in IDLE.
- idx  out  SEL_W  registered current index.
- wrap  out  1  one-cycle pulse when scan index wraps OUT_W-1 -> 0.

## Operation
- States: IDLE, DIRECT, SCAN. Internal dwell counter div_cnt, width clog2(DIV) (min 1).
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE, idx=0, div_cnt=0, y=0, wrap=0.
- Priority each edge: en=0 > mode select > load / dwell step.
- IDLE:
  - en=0: stay; outputs hold reset-like values (y=0, wrap=0); idx holds its last value.
  - en=1, mode=0: go to DIRECT. idx <= (load ? sel_in : idx).
  - en=1, mode=1: go to SCAN. idx <= 0, div_cnt <= 0.
- DIRECT:
  - load=1: idx <= sel_in. load=0: idx holds.
  - mode=1: go to SCAN; idx kept, div_cnt <= 0.
- SCAN:
  - div_cnt increments each cycle.
  - When div_cnt == DIV-1: div_cnt <= 0 and idx <= idx+1, modulo OUT_W (natural SEL_W-bit wrap).
  - mode=0: go to DIRECT; idx kept, div_cnt <= 0. load in that same cycle applies.
- Any state with en=0: next state IDLE; y <= 0, div_cnt <= 0, wrap <= 0; idx holds.
- y is registered from the next-state/next-idx values: y <= onehot(next idx) when next state != IDLE, else 0. y and idx always change on the same edge.
- Invariant: popcount(y) <= 1 every cycle; y != 0 iff state != IDLE.
- wrap is registered: high for exactly the one cycle after the edge on which idx steps OUT_W-1 -> 0 in SCAN.
  - SCAN entry (idx forced to 0) does not assert wrap.
  - A direct load of 0 does not assert wrap.

## Timing
- Direct latency: sel_in with load=1 at edge k appears on idx/y after edge k (one cycle).
- Scan: entry at edge k gives y=1 from edge k. idx advances at edges k+DIV, k+2·DIV, …
  - Full sweep = OUT_W·DIV cycles. wrap high after edge k+OUT_W·DIV.
- DIV=1: idx advances every cycle; wrap every OUT_W cycles.
- en fall: y=0 after the next edge, never mid-cycle.
- Async reset mid-operation clears outputs immediately. Deassertion is synchronous to the next rising edge by usage; first active edge behaves as from IDLE.
- Mode switch takes effect at the sampling edge; no dead cycle with y=0.

## Test plan
- Reset: rst_n=0 mid-scan with no clock edge -> y=0x00, idx=0, wrap=0 immediately. Release, en=0 -> y stays 0x00.
- Direct decode (SEL_W=3): en=1, mode=0, load=1, sel_in=5 -> next cycle y=0x20, idx=5. load=0 with sel_in=2 -> y holds 0x20. Sweep all 8 values -> y = 1<<sel_in.
- Scan, SEL_W=3, DIV=2: en=1, mode=1 -> y=0x01,0x01,0x02,0x02,…,0x80,0x80,0x01. wrap high only in the first 0x01 cycle after 0x80 (cycle 16 after entry).
- Scan, DIV=1, SEL_W=2 -> y=1,2,4,8,1. wrap every 4 cycles. Check popcount(y) <= 1 throughout.
- en drop mid-scan with load=1 the same cycle -> next cycle y=0, idx held, wrap=0. Re-enable with mode=1 -> restart at y=0x01.
- Mode switch: scanning at idx=3, set mode=0 with load=1, sel_in=6 -> next y=0x40. Back to mode=1 -> scan continues 6,7,0 (wrap asserts on 0) with full DIV dwell on 6.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// Registered one-hot select decoder with direct-load and auto-scan modes.
// Scan mode dwells DIV cycles per line and pulses wrap at the end of each sweep.
module decoder_scan_seq #(
    parameter int SEL_W = 3,
    parameter int DIV   = 4,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel_in,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    div_q, div_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        wrap_d  = 1'b0;
        y_d     = '0;

        if (!en) begin
            state_d = IDLE;
            div_d   = '0;
        end else if (!mode) begin
            state_d = DIRECT;
            div_d   = '0;
            if (load) begin
                idx_d = sel_in;
            end
        end else begin
            state_d = SCAN;
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    div_d = '0;
                end
                DIRECT: begin
                    div_d = '0;
                end
                SCAN: begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        idx_d  = idx_q + 1'b1;
                        wrap_d = &idx_q;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    idx_d = '0;
                    div_d = '0;
                end
            endcase
        end

        // Output decodes the next index so y and idx move on the same edge.
        if (state_d != IDLE) begin
            y_d = {{(OUT_W-1){1'b0}}, 1'b1} << idx_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
